// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO write/read arbitration controller.
package fifo_pkg;

  localparam int DW     = 8;                  // requester / FIFO data width
  localparam int DEPTH  = 16;                 // FIFO entries (2**pointer width)
  localparam int CW     = $clog2(DEPTH + 1);  // occupancy count width, holds 0..DEPTH
  localparam int RD_LAT = 1;                  // fifo_rd to FIFO dout valid, in cycles

  // Encoding of the round-robin "last winner" register.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Occupancy after one edge: a lone write adds one, a lone read removes one.
  function automatic logic [CW-1:0] count_step(input logic [CW-1:0] cnt,
                                               input logic          wr,
                                               input logic          rd);
    logic [CW-1:0] res;
    res = cnt;
    if (wr && !rd) begin
      res = cnt + CW'(1);
    end else if (rd && !wr) begin
      res = cnt - CW'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot winner among eligible requesters,
// preferring the one that did not win the last contended round.
module rr_arb2
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  input  logic       en,
  output logic [1:0] win,
  output logic       rr_last
);

  logic rr_last_reg;
  logic rr_last_next;

  // Winner selection; rr_last only moves when both requesters contend.
  always_comb begin
    win          = 2'b00;
    rr_last_next = rr_last_reg;
    if (en) begin
      case (elig)
        2'b01: win = 2'b01;
        2'b10: win = 2'b10;
        2'b11: begin
          if (rr_last_reg == REQ0) begin
            win          = 2'b10;
            rr_last_next = REQ1;
          end else begin
            win          = 2'b01;
            rr_last_next = REQ0;
          end
        end
        default: win = 2'b00;
      endcase
    end
  end

  // Last-winner register; resets to REQ1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_reg <= REQ1;
    end else begin
      rr_last_reg <= rr_last_next;
    end
  end

  assign rr_last = rr_last_reg;

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Arbitrates two write requesters and one reader onto a shared 16-entry FIFO,
// tracking occupancy internally because the FIFO exposes no full/empty flags.
module fifo_arb_ctrl
  import fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  input  logic          rd_req,
  output logic          rd_gnt,
  output logic          rd_vld,
  output logic          fifo_wr,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_rd,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          gnt0_reg;
  logic          gnt1_reg;
  logic          rd_gnt_reg;
  logic          fifo_wr_reg;
  logic          fifo_rd_reg;
  logic [DW-1:0] fifo_din_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic [RD_LAT-1:0] vld_pipe_reg;
  logic [RD_LAT-1:0] vld_pipe_next;

  logic [1:0] elig;
  logic [1:0] win;
  logic       wr_acc;
  logic       rd_acc;
  logic       rr_last;
  logic       unused_rr_last;

  // A requester whose grant is currently visible sits out one edge so the
  // same held data is never sampled twice.
  assign elig   = {req1 & ~gnt1_reg, req0 & ~gnt0_reg};
  assign wr_acc = (|elig) && (count_reg != FULL_CNT);
  assign rd_acc = rd_req && !rd_gnt_reg && (count_reg != '0);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .elig    (elig),
    .en      (wr_acc),
    .win     (win),
    .rr_last (rr_last)
  );

  // The arbiter history is only of diagnostic interest at this level.
  assign unused_rr_last = rr_last;

  // Occupancy follows the accepts decided at this same edge.
  always_comb begin
    count_next = count_step(count_reg, wr_acc, rd_acc);
  end

  // rd_vld delay line: stage 0 takes fifo_rd, later stages shift along.
  assign vld_pipe_next[0] = fifo_rd_reg;
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld_pipe
      assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
    end
  endgenerate

  // Registered grants, FIFO strobes, write data and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      rd_gnt_reg   <= 1'b0;
      fifo_wr_reg  <= 1'b0;
      fifo_rd_reg  <= 1'b0;
      fifo_din_reg <= '0;
      count_reg    <= '0;
      vld_pipe_reg <= '0;
    end else begin
      gnt0_reg     <= win[0];
      gnt1_reg     <= win[1];
      fifo_wr_reg  <= wr_acc;
      fifo_rd_reg  <= rd_acc;
      rd_gnt_reg   <= rd_acc;
      count_reg    <= count_next;
      vld_pipe_reg <= vld_pipe_next;
      if (wr_acc) begin
        fifo_din_reg <= win[1] ? din1 : din0;
      end
    end
  end

  assign gnt0     = gnt0_reg;
  assign gnt1     = gnt1_reg;
  assign rd_gnt   = rd_gnt_reg;
  assign fifo_wr  = fifo_wr_reg;
  assign fifo_rd  = fifo_rd_reg;
  assign fifo_din = fifo_din_reg;
  assign rd_vld   = vld_pipe_reg[RD_LAT-1];
  assign count    = count_reg;
  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed scenarios followed by random traffic, checked every edge against
// a behavioural model of the arbitration and occupancy rules.
module tb_fifo_arb_ctrl;
  import fifo_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, rd_req;
  logic [DW-1:0] din0, din1;
  logic          gnt0, gnt1, rd_gnt, rd_vld, fifo_wr, fifo_rd, full, empty;
  logic [DW-1:0] fifo_din;
  logic [CW-1:0] count;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model state (what the outputs should be after the last edge).
  int        m_count;
  int        m_last;
  bit        m_gnt0, m_gnt1, m_wr, m_rd, m_rdgnt, m_rdvld;
  bit [7:0]  m_din;

  fifo_arb_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .gnt0(gnt0),
    .req1(req1), .din1(din1), .gnt1(gnt1),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_vld(rd_vld),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: apply the rules to the sampled inputs, then compare.
  task automatic step();
    bit e0, e1, w, r;
    int win;
    @(posedge clk);
    if (rst) begin
      m_count = 0; m_last = 1;
      m_gnt0 = 0; m_gnt1 = 0; m_wr = 0; m_rd = 0; m_rdgnt = 0; m_rdvld = 0; m_din = 8'h00;
      w = 0; r = 0;
    end else begin
      e0  = req0 && !m_gnt0;
      e1  = req1 && !m_gnt1;
      w   = (e0 || e1) && (m_count < DEPTH);
      win = -1;
      if (w) begin
        if (e0 && e1) begin
          win    = (m_last == 0) ? 1 : 0;
          m_last = win;
        end else begin
          win = e0 ? 0 : 1;
        end
        m_din = (win == 1) ? din1 : din0;
      end
      r       = rd_req && !m_rdgnt && (m_count > 0);
      m_rdvld = m_rd;
      m_rd    = r;
      m_rdgnt = r;
      m_wr    = w;
      m_gnt0  = (win == 0);
      m_gnt1  = (win == 1);
      m_count = m_count + int'(w) - int'(r);
    end
    #1;
    chk("gnt0",     8'(gnt0),     8'(m_gnt0));
    chk("gnt1",     8'(gnt1),     8'(m_gnt1));
    chk("fifo_wr",  8'(fifo_wr),  8'(m_wr));
    chk("fifo_din", fifo_din,     m_din);
    chk("fifo_rd",  8'(fifo_rd),  8'(m_rd));
    chk("rd_gnt",   8'(rd_gnt),   8'(m_rdgnt));
    chk("rd_vld",   8'(rd_vld),   8'(m_rdvld));
    chk("count",    8'(count),    8'(m_count));
    chk("full",     8'(full),     8'(m_count == DEPTH));
    chk("empty",    8'(empty),    8'(m_count == 0));
    if (rst || w || r || m_rdvld)
      $display("t=%0t rst=%0b gnt=%0b%0b wr=%0b din=%02h rd=%0b vld=%0b count=%0d",
               $time, rst, gnt1, gnt0, fifo_wr, fifo_din, fifo_rd, rd_vld, count);
  endtask

  // Move occupancy to a target with single-requester writes or reads.
  task automatic drive_to(input int target);
    int guard = 0;
    rst = 0; req1 = 0; din0 = 8'($urandom);
    while (m_count != target && guard < 100) begin
      req0   = (m_count < target);
      rd_req = (m_count > target);
      step();
      guard++;
    end
    req0 = 0; rd_req = 0;
    chk("drive_to", 8'(count), 8'(target));
  endtask

  initial begin
    rst = 1; req0 = 0; req1 = 0; rd_req = 0; din0 = 8'h00; din1 = 8'h00;
    // Reset state
    step(); step();
    chk("rst_empty", 8'(empty), 8'd1);
    rst = 0;

    // Single writer
    req0 = 1; din0 = 8'hA5;
    step();
    chk("single_gnt0", 8'(gnt0), 8'd1);
    chk("single_din",  fifo_din, 8'hA5);
    req0 = 0;
    step(); step();

    // Contention: both requesters held high
    req0 = 1; din0 = 8'h11; req1 = 1; din1 = 8'h22;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("one_grant", 8'(gnt0 & gnt1), 8'd0);
    end
    req0 = 0; req1 = 0;
    step();

    // Full: writes refused while count==DEPTH
    drive_to(DEPTH);
    req0 = 1;
    step(); step(); step();
    chk("full_flag", 8'(full), 8'd1);
    rd_req = 1;
    step();
    rd_req = 0;
    step();
    chk("full_refill", 8'(count), 8'(DEPTH));
    req0 = 0;
    step();

    // Empty: read and write together at count==0
    drive_to(0);
    step();
    rd_req = 1; req1 = 1; din1 = 8'h3C;
    step();
    chk("empty_no_rd", 8'(rd_gnt), 8'd0);
    req1 = 0;
    step();
    rd_req = 0;
    step(); step();

    // Simultaneous write and read at count==5
    drive_to(5);
    step();
    req0 = 1; din0 = 8'h5A; rd_req = 1;
    step();
    chk("simul_both", 8'(fifo_wr & fifo_rd), 8'd1);
    chk("simul_cnt",  8'(count), 8'd5);
    req0 = 0; rd_req = 0;
    step(); step();

    // Reset mid-operation
    drive_to(7);
    req0 = 1; rd_req = 1; din0 = 8'h77; rst = 1;
    step();
    chk("mid_rst_cnt",   8'(count), 8'd0);
    chk("mid_rst_empty", 8'(empty), 8'd1);
    rst = 0;
    step();
    chk("post_rst_gnt0", 8'(gnt0), 8'd1);
    chk("post_rst_rd",   8'(rd_gnt), 8'd0);
    step(); step();
    req0 = 0; rd_req = 0;
    step();

    // Random traffic: write-heavy phase then read-heavy phase
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      req0   = ($urandom_range(0, 3) != 0);
      req1   = ($urandom_range(0, 3) != 0);
      rd_req = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (i >= 200) begin
        req0 = req0 & ($urandom_range(0, 2) == 0);
        req1 = req1 & ($urandom_range(0, 2) == 0);
      end
      if (m_gnt0 || !req0) din0 = 8'($urandom);
      if (m_gnt1 || !req1) din1 = 8'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
